energy_sweep_ctrl: RTL and testbench
====================================

Name: energy_sweep_ctrl

Overview:
Sequential driver for the combinational single-spin partial energy calculator. On start it captures a spin vector and h-scaling factor, then loops over every spin index. For each index it fetches that spin's J row and h bias over a valid/ready memory port, presents them to the calculator, and accumulates the returned local energy. The total energy is delivered on a valid/ready output; the block sits between the weight/bias memory and the annealer's energy-monitoring logic.

Parameters:
BITJ, 4, bit precision of J entries
BITH, 4, bit precision of h
DATASPIN, 256, number of spins (≥1)
SCALING_BIT, 5, width of h scaling factor
LOCAL_ENERGY_BIT, 16, width of calculator energy
DATAJ, DATASPIN*BITJ, width of one J row
ADDRW, max(1,$clog2(DATASPIN)), row address width
TOTAL_ENERGY_BIT, LOCAL_ENERGY_BIT+$clog2(DATASPIN)+1, accumulator/output width (overflow-free)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  start a sweep (honoured only in IDLE)
spin_i  in  DATASPIN  spin vector, captured on accepted start
hscaling_i  in  SCALING_BIT  h scaling, captured on accepted start
busy_o  out  1  high from accepted start until energy handshake completes
wreq_valid_o  out  1  row read request valid
wreq_ready_i  in  1  row read request ready
wreq_addr_o  out  ADDRW  row index being requested
wresp_valid_i  in  1  row response valid (no ready; one outstanding request max)
wresp_weight_i  in  DATAJ  J row for requested spin
wresp_hbias_i  in  BITH  signed h for requested spin
calc_spin_o  out  DATASPIN  captured spin vector to calculator
calc_current_spin_o  out  1  spin[idx] to calculator
calc_weight_o  out  DATAJ  registered J row
calc_hbias_o  out  BITH  registered h
calc_hscaling_o  out  SCALING_BIT  captured scaling
calc_energy_i  in  LOCAL_ENERGY_BIT  signed local energy from calculator
energy_valid_o  out  1  total energy valid
energy_ready_i  in  1  total energy ready
energy_o  out  TOTAL_ENERGY_BIT  signed total energy

Behaviour:
- Reset (rst_ni low at a clock edge): state IDLE; idx, accumulator, energy_o, all calc_* registers, wreq_addr_o = 0; busy_o, wreq_valid_o, energy_valid_o = 0. Reset mid-sweep aborts with no output; in-flight wresp ignored.
- States: IDLE, REQ, WAIT, ACC, OUT.
- IDLE: start_i=1 → capture spin_i, hscaling_i; idx=0; acc=0; → REQ. busy_o=1 from the next cycle.
- REQ: wreq_valid_o=1, wreq_addr_o=idx; both held stable until wreq_ready_i. On handshake → WAIT.
- WAIT: on wresp_valid_i register weight/hbias into calc_weight_o/calc_hbias_o and calc_current_spin_o = spin[idx]; → ACC. Same-cycle response to request not allowed (earliest one cycle after accept).
- ACC: acc += sign-extended calc_energy_i (calculator is combinational on registered inputs). If idx==DATASPIN-1 → OUT, else idx++ → REQ.
- OUT: energy_o=acc, energy_valid_o=1; held stable until energy_ready_i; on handshake → IDLE, busy_o and energy_valid_o drop the next cycle. energy_o retains its value in IDLE.
- Minimum latency (ready always high, response 1 cycle after accept): 3 cycles/spin; energy_valid_o asserts 3*DATASPIN+1 cycles after start cycle.
- start_i while busy: ignored, no capture. wresp_valid_i outside WAIT: ignored.
- Arithmetic: two's-complement, no saturation; width guarantees no overflow.
- hscaling not a power of 2 is passed through unchanged (calculator treats it as ×1).

Decomposition:
- Package energy_sweep_pkg: state enum, function computing ADDRW/TOTAL_ENERGY_BIT.
- No sub-module inside; partial_energy_calc instantiated alongside at the parent level, wired via calc_* ports. Bench instantiates both.

Test Plan:
- DATASPIN=4, spins 4'b1111, all J=+1, h=0, scaling 1 → each local +4, energy_o=16; valid at cycle 13 after start.
- DATASPIN=4, spins 4'b0000, J=0, h=+2, scaling 4 → each local −8, energy_o=−32; spins 4'b1111 same data → +32.
- Spins 4'b0101, J=+1, h=0 → each row sum 0, energy_o=0.
- wreq_ready_i low 5 cycles on row 2 → wreq_addr_o=2 and valid held stable; result unchanged; energy_ready_i low 3 cycles → energy_o/valid held.
- start_i pulsed mid-sweep with different spins → ignored, result matches first capture; rst_ni low during WAIT of row 1 → all outputs zero next cycle, new start produces correct total.

Source files
------------

// File: rtl/energy_sweep_pkg.sv
// Shared types and width helpers for the energy sweep controller.
// The derived-width functions keep the parameter defaults in one place.
package energy_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_OUT  = 3'd4
    } sweep_state_e;

    // Row address width; a single-spin system still needs one address bit.
    function automatic int calc_addrw(input int dataspin);
        if (dataspin > 1) begin
            return $clog2(dataspin);
        end else begin
            return 1;
        end
    endfunction

    // Accumulator width large enough that summing every local energy cannot overflow.
    function automatic int calc_total_energy_bit(input int local_bits, input int dataspin);
        return local_bits + $clog2(dataspin) + 1;
    endfunction

endpackage

// File: rtl/energy_sweep_ctrl.sv
// Sequential driver for the single-spin partial energy calculator: fetches one J row
// and h bias per spin, feeds the calculator, and sums the returned local energies.
module energy_sweep_ctrl
    import energy_sweep_pkg::*;
#(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16,
    parameter int DATAJ            = DATASPIN * BITJ,
    parameter int ADDRW            = calc_addrw(DATASPIN),
    parameter int TOTAL_ENERGY_BIT = calc_total_energy_bit(LOCAL_ENERGY_BIT, DATASPIN)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [DATASPIN-1:0]                spin_i,
    input  logic [SCALING_BIT-1:0]             hscaling_i,
    output logic                               busy_o,
    output logic                               wreq_valid_o,
    input  logic                               wreq_ready_i,
    output logic [ADDRW-1:0]                   wreq_addr_o,
    input  logic                               wresp_valid_i,
    input  logic [DATAJ-1:0]                   wresp_weight_i,
    input  logic [BITH-1:0]                    wresp_hbias_i,
    output logic [DATASPIN-1:0]                calc_spin_o,
    output logic                               calc_current_spin_o,
    output logic [DATAJ-1:0]                   calc_weight_o,
    output logic [BITH-1:0]                    calc_hbias_o,
    output logic [SCALING_BIT-1:0]             calc_hscaling_o,
    input  logic [LOCAL_ENERGY_BIT-1:0]        calc_energy_i,
    output logic                               energy_valid_o,
    input  logic                               energy_ready_i,
    output logic [TOTAL_ENERGY_BIT-1:0]        energy_o
);

    sweep_state_e                  state_r;
    sweep_state_e                  state_s;
    logic [ADDRW-1:0]              idx_r;
    logic [TOTAL_ENERGY_BIT-1:0]   acc_r;
    logic [TOTAL_ENERGY_BIT-1:0]   energy_ext_s;
    logic [TOTAL_ENERGY_BIT-1:0]   acc_sum_s;
    logic                          last_s;

    assign energy_ext_s = {{(TOTAL_ENERGY_BIT - LOCAL_ENERGY_BIT){calc_energy_i[LOCAL_ENERGY_BIT-1]}},
                           calc_energy_i};
    assign acc_sum_s    = acc_r + energy_ext_s;
    assign last_s       = (idx_r == ADDRW'(DATASPIN - 1));
    assign wreq_addr_o  = idx_r;

    // Next-state selection for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (wreq_ready_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (wresp_valid_i) begin
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACC: begin
                if (last_s) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_OUT: begin
                if (energy_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake flags, registered from the upcoming state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r        <= ST_IDLE;
            busy_o         <= 1'b0;
            wreq_valid_o   <= 1'b0;
            energy_valid_o <= 1'b0;
        end else begin
            state_r        <= state_s;
            busy_o         <= (state_s != ST_IDLE);
            wreq_valid_o   <= (state_s == ST_REQ);
            energy_valid_o <= (state_s == ST_OUT);
        end
    end

    // Operand capture, row indexing and energy accumulation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_r               <= '0;
            acc_r               <= '0;
            energy_o            <= '0;
            calc_spin_o         <= '0;
            calc_current_spin_o <= 1'b0;
            calc_weight_o       <= '0;
            calc_hbias_o        <= '0;
            calc_hscaling_o     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        calc_spin_o     <= spin_i;
                        calc_hscaling_o <= hscaling_i;
                        idx_r           <= '0;
                        acc_r           <= '0;
                    end
                end
                ST_WAIT: begin
                    // Responses only count while a request is outstanding.
                    if (wresp_valid_i) begin
                        calc_weight_o       <= wresp_weight_i;
                        calc_hbias_o        <= wresp_hbias_i;
                        calc_current_spin_o <= calc_spin_o[idx_r];
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_sum_s;
                    if (last_s) begin
                        energy_o <= acc_sum_s;
                    end else begin
                        idx_r <= idx_r + ADDRW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_energy_sweep_ctrl.sv
// Directed/randomized bench for energy_sweep_ctrl with a behavioural calculator
// and a whole-sweep Ising energy reference.
module tb_energy_sweep_ctrl;

    localparam int NS   = 4;
    localparam int BITJ = 4;
    localparam int BITH = 4;
    localparam int SB   = 5;
    localparam int LEB  = 16;
    localparam int TEB  = 19;
    localparam int AW   = 2;
    localparam int DJ   = NS * BITJ;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NS-1:0]   spin;
    logic [SB-1:0]   hscaling;
    logic            busy;
    logic            wreq_valid;
    logic            wreq_ready;
    logic [AW-1:0]   wreq_addr;
    logic            wresp_valid;
    logic [DJ-1:0]   wresp_weight;
    logic [BITH-1:0] wresp_hbias;
    logic [NS-1:0]   calc_spin;
    logic            calc_cur;
    logic [DJ-1:0]   calc_weight;
    logic [BITH-1:0] calc_hbias;
    logic [SB-1:0]   calc_hscaling;
    logic [LEB-1:0]  calc_energy;
    logic            energy_valid;
    logic            energy_ready;
    logic [TEB-1:0]  energy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [BITJ-1:0] j_mem [NS][NS];
    logic signed [BITH-1:0] h_mem [NS];

    always #5 clk = ~clk;

    energy_sweep_ctrl #(.DATASPIN(NS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .spin_i(spin), .hscaling_i(hscaling),
        .busy_o(busy), .wreq_valid_o(wreq_valid), .wreq_ready_i(wreq_ready), .wreq_addr_o(wreq_addr),
        .wresp_valid_i(wresp_valid), .wresp_weight_i(wresp_weight), .wresp_hbias_i(wresp_hbias),
        .calc_spin_o(calc_spin), .calc_current_spin_o(calc_cur), .calc_weight_o(calc_weight),
        .calc_hbias_o(calc_hbias), .calc_hscaling_o(calc_hscaling), .calc_energy_i(calc_energy),
        .energy_valid_o(energy_valid), .energy_ready_i(energy_ready), .energy_o(energy_o)
    );

    function automatic int scale_of(input logic [SB-1:0] s);
        if (s != 5'd0 && (s & (s - 5'd1)) == 5'd0) return int'(s);
        else return 1;
    endfunction

    // Calculator model: local energy = sigma_i * (sum_j J_ij*sigma_j + h_i*scale).
    always_comb begin
        int f;
        f = int'($signed(calc_hbias)) * scale_of(calc_hscaling);
        for (int j = 0; j < NS; j++)
            f += (calc_spin[j] ? 1 : -1) * int'($signed(calc_weight[j*BITJ +: BITJ]));
        if (calc_cur) calc_energy = LEB'(f);
        else          calc_energy = LEB'(-f);
    end

    function automatic logic signed [63:0] ref_energy(input logic [NS-1:0] sp, input logic [SB-1:0] hs);
        int total, field, jv;
        total = 0;
        for (int i = 0; i < NS; i++) begin
            field = int'(h_mem[i]) * scale_of(hs);
            for (int j = 0; j < NS; j++) begin
                jv = int'(j_mem[i][j]);
                field += sp[j] ? jv : -jv;
            end
            total += sp[i] ? field : -field;
        end
        return total;
    endfunction

    function automatic logic [DJ-1:0] row_of(input int r);
        logic [DJ-1:0] w;
        for (int j = 0; j < NS; j++) w[j*BITJ +: BITJ] = j_mem[r][j];
        return w;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_uniform(input int jv, input int hv);
        for (int i = 0; i < NS; i++) begin
            h_mem[i] = BITH'(hv);
            for (int j = 0; j < NS; j++) j_mem[i][j] = BITJ'(jv);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NS; i++) begin
            h_mem[i] = BITH'($urandom);
            for (int j = 0; j < NS; j++) j_mem[i][j] = BITJ'($urandom);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wreq_valid"}, wreq_valid, 0);
        check({tag, "_energy_valid"}, energy_valid, 0);
        check({tag, "_energy"}, energy_o, 0);
        check({tag, "_addr"}, wreq_addr, 0);
        check({tag, "_calc_weight"}, calc_weight, 0);
        check({tag, "_calc_hbias"}, calc_hbias, 0);
        check({tag, "_calc_spin"}, calc_spin, 0);
        check({tag, "_calc_cur"}, calc_cur, 0);
        check({tag, "_calc_hscaling"}, calc_hscaling, 0);
    endtask

    // One full sweep with optional request stall, output stall, mid-sweep start and response jitter.
    task automatic run_sweep(input logic [NS-1:0] sp, input logic [SB-1:0] hs, input int stall_row,
                             input int stall_cyc, input int e_stall, input bit glitch, input bit lat,
                             input bit rnd);
        int cyc, waitc, d;
        logic signed [63:0] exp_e;
        exp_e = ref_energy(sp, hs);
        @(negedge clk); start = 1'b1; spin = sp; hscaling = hs;
        @(negedge clk); cyc = 1; start = 1'b0; spin = ~sp; hscaling = SB'($urandom);
        check("busy_after_start", busy, 1);
        for (int r = 0; r < NS; r++) begin
            waitc = 0;
            while (wreq_valid !== 1'b1 && waitc < 20) begin @(negedge clk); cyc++; waitc++; end
            check("req_valid", wreq_valid, 1);
            check("req_addr", wreq_addr, r);
            if (r == stall_row) begin
                for (int k = 0; k < stall_cyc; k++) begin
                    wresp_valid = k[0]; wresp_weight = DJ'($urandom); wresp_hbias = BITH'($urandom);
                    @(negedge clk); cyc++;
                    check("stall_valid", wreq_valid, 1);
                    check("stall_addr", wreq_addr, r);
                end
                wresp_valid = 1'b0;
            end
            if (glitch && r == 1) begin start = 1'b1; spin = sp ^ 4'b0110; hscaling = hs + 5'd1; end
            wreq_ready = 1'b1;
            @(negedge clk); cyc++; wreq_ready = 1'b0; start = 1'b0;
            check("wait_req_low", wreq_valid, 0);
            d = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < d; k++) begin @(negedge clk); cyc++; end
            wresp_valid = 1'b1; wresp_weight = row_of(r); wresp_hbias = h_mem[r];
            @(negedge clk); cyc++; wresp_valid = 1'b0; wresp_weight = '0; wresp_hbias = '0;
        end
        waitc = 0;
        while (energy_valid !== 1'b1 && waitc < 20) begin @(negedge clk); cyc++; waitc++; end
        check("energy_valid", energy_valid, 1);
        if (lat) check("latency", cyc, 3 * NS + 1);
        check("energy", $signed(energy_o), exp_e);
        for (int k = 0; k < e_stall; k++) begin
            @(negedge clk);
            check("hold_valid", energy_valid, 1);
            check("hold_energy", $signed(energy_o), exp_e);
        end
        energy_ready = 1'b1;
        @(negedge clk); energy_ready = 1'b0;
        check("valid_drop", energy_valid, 0);
        check("busy_drop", busy, 0);
        check("energy_retained", $signed(energy_o), exp_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NS-1:0] sp;
        rst_n = 1'b0; start = 1'b1; spin = 4'b1010; hscaling = 5'd4; wreq_ready = 1'b0;
        wresp_valid = 1'b0; wresp_weight = '0; wresp_hbias = '0; energy_ready = 1'b0;
        fill_uniform(0, 0);
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        fill_uniform(1, 0);
        run_sweep(4'b1111, 5'd1, -1, 0, 0, 1'b0, 1'b1, 1'b0);      // +16, latency 13
        fill_uniform(0, 2);
        run_sweep(4'b0000, 5'd4, -1, 0, 0, 1'b0, 1'b1, 1'b0);      // -32
        run_sweep(4'b1111, 5'd4, -1, 0, 0, 1'b0, 1'b0, 1'b0);      // +32

        // Abort during WAIT of row 1; a response arrives alongside the reset.
        fill_random();
        @(negedge clk); start = 1'b1; spin = 4'b1011; hscaling = 5'd2;
        @(negedge clk); start = 1'b0; wreq_ready = 1'b1;
        @(negedge clk); wreq_ready = 1'b0; wresp_valid = 1'b1; wresp_weight = row_of(0); wresp_hbias = h_mem[0];
        @(negedge clk); wresp_valid = 1'b0;
        @(negedge clk); check("abort_addr", wreq_addr, 1); wreq_ready = 1'b1;
        @(negedge clk); wreq_ready = 1'b0;
        rst_n = 1'b0; wresp_valid = 1'b1; wresp_weight = row_of(1); wresp_hbias = h_mem[1];
        @(negedge clk);
        check_cleared("abort");
        rst_n = 1'b1; wresp_valid = 1'b0;
        @(negedge clk);
        check("post_abort_idle", busy, 0);
        run_sweep(4'b1011, 5'd2, -1, 0, 0, 1'b0, 1'b1, 1'b0);

        fill_uniform(1, 0);
        run_sweep(4'b0101, 5'd8, -1, 0, 0, 1'b0, 1'b0, 1'b0);      // 0

        fill_random();
        run_sweep(4'($urandom), 5'd16, 2, 5, 3, 1'b0, 1'b0, 1'b0);  // stalls
        fill_random();
        run_sweep(4'($urandom), 5'd2, -1, 0, 0, 1'b1, 1'b0, 1'b0);  // ignored start

        for (int t = 0; t < 6; t++) begin
            fill_random();
            sp = NS'($urandom);
            run_sweep(sp, SB'($urandom), int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
